// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - PC owner and instruction-fetch sequencer with EX-stage redirect handling
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        jump_flag,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misaligned,
    output logic [31:0] redirect_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        take_word;
    logic        hold_load;
    logic        hold_deliver;
    logic        pc_advance;
    logic        drain_load;

    assign redirect    = ex_valid & jump_flag;
    assign redirect_pc = {next_pc[31:2], 2'b00};
    assign flush_if    = redirect;
    assign flush_id    = redirect;

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        imem_addr    = pc;
        take_word    = 1'b0;
        hold_load    = 1'b0;
        hold_deliver = 1'b0;
        pc_advance   = 1'b0;
        drain_load   = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // An unacked request must be allowed to complete before the target is issued.
                    if (!imem_ack) begin
                        state_nxt  = DRAIN;
                        drain_load = 1'b1;
                    end
                end else if (imem_ack) begin
                    pc_advance = 1'b1;
                    if (stall) begin
                        hold_load = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        take_word = 1'b1;
                    end
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = FETCH;
                end else if (!stall) begin
                    hold_deliver = 1'b1;
                    state_nxt    = FETCH;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (pc_advance) begin
                pc <= pc + 32'd4;
            end
            if (drain_load) begin
                drain_addr <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc   <= 32'h0;
            hold_inst <= NOP;
        end else if (hold_load) begin
            hold_pc   <= pc;
            hold_inst <= imem_rdata;
        end
    end

    // if_* only change when decode consumes (stall=0) or a redirect kills the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_inst  <= NOP;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (take_word) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_inst  <= imem_rdata;
        end else if (hold_deliver) begin
            if_valid <= 1'b1;
            if_pc    <= hold_pc;
            if_inst  <= hold_inst;
        end else if (!stall) begin
            if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned   <= 1'b0;
            redirect_cnt <= 32'h0;
        end else begin
            misaligned <= redirect & (|next_pc[1:0]);
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] KEY = 32'hC0DE_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        rst1_n;
    logic        stall;
    logic        ex_valid;
    logic        jump_flag;
    logic [31:0] next_pc;

    logic        req0, ack0, ifv0, fif0, fid0, mis0;
    logic [31:0] addr0, rdata0, ifpc0, ifinst0, cnt0;
    logic        req1, ack1, ifv1, fif1, fid1, mis1;
    logic [31:0] addr1, rdata1, ifpc1, ifinst1, cnt1;

    int total;
    int bad;
    int wait_cfg;
    int wait_cnt;

    fetch_redirect_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
        .jump_flag(jump_flag), .next_pc(next_pc),
        .imem_req(req0), .imem_addr(addr0), .imem_ack(ack0), .imem_rdata(rdata0),
        .if_valid(ifv0), .if_pc(ifpc0), .if_inst(ifinst0),
        .flush_if(fif0), .flush_id(fid0), .misaligned(mis0), .redirect_cnt(cnt0)
    );

    fetch_redirect_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .stall(stall), .ex_valid(ex_valid),
        .jump_flag(jump_flag), .next_pc(next_pc),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
        .if_valid(ifv1), .if_pc(ifpc1), .if_inst(ifinst1),
        .flush_if(fif1), .flush_id(fid1), .misaligned(mis1), .redirect_cnt(cnt1)
    );

    // Memory models: dut0 acks after wait_cfg cycles, dut1 is zero-wait.
    assign ack0   = req0 && (wait_cnt >= wait_cfg);
    assign rdata0 = addr0 ^ KEY;
    assign ack1   = req1;
    assign rdata1 = addr1 ^ KEY;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (req0 && !ack0) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0; wait_cfg = 0;
        rst_n = 1'b0; rst1_n = 1'b0; stall = 1'b0;
        ex_valid = 1'b0; jump_flag = 1'b0; next_pc = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'b0, req0}, 32'h0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_ifv", {31'b0, ifv0}, 32'h0);
        chk("rst_ifpc", ifpc0, 32'h0);
        chk("rst_ifinst", ifinst0, NOP);
        chk("rst_mis", {31'b0, mis0}, 32'h0);
        chk("rst_cnt", cnt0, 32'h0);
        chk("rst_flush", {30'b0, fif0, fid0}, 32'h0);

        @(negedge clk); rst_n = 1'b1; #1;
        chk("boot_req", {31'b0, req0}, 32'h0);
        @(negedge clk); #1;
        chk("f0_req", {31'b0, req0}, 32'h1);
        chk("f0_addr", addr0, 32'h0);
        chk("f0_ifv", {31'b0, ifv0}, 32'h0);
        @(negedge clk); #1;
        chk("f1_addr", addr0, 32'h4);
        chk("f1_ifv", {31'b0, ifv0}, 32'h1);
        chk("f1_ifpc", ifpc0, 32'h0);
        chk("f1_ifinst", ifinst0, 32'h0 ^ KEY);
        @(negedge clk); #1;
        chk("f2_addr", addr0, 32'h8);
        chk("f2_ifpc", ifpc0, 32'h4);

        // redirect to 0x100 in the cycle 0x8 is acked
        ex_valid = 1'b1; jump_flag = 1'b1; next_pc = 32'h100; #1;
        chk("r1_flush_if", {31'b0, fif0}, 32'h1);
        chk("r1_flush_id", {31'b0, fid0}, 32'h1);
        @(negedge clk); ex_valid = 1'b0; jump_flag = 1'b0; #1;
        chk("r1_addr", addr0, 32'h100);
        chk("r1_cnt", cnt0, 32'h1);
        chk("r1_ifv", {31'b0, ifv0}, 32'h0);
        chk("r1_noflush", {31'b0, fif0}, 32'h0);
        @(negedge clk); #1;
        chk("r1_ifv2", {31'b0, ifv0}, 32'h1);
        chk("r1_ifpc", ifpc0, 32'h100);
        chk("r1_ifinst", ifinst0, 32'h100 ^ KEY);
        chk("r1_addr2", addr0, 32'h104);

        ex_valid = 1'b1; jump_flag = 1'b1; next_pc = 32'h20;
        @(negedge clk); ex_valid = 1'b0; jump_flag = 1'b0; wait_cfg = 3; #1;
        chk("w_a_addr", addr0, 32'h20);
        chk("w_a_cnt", cnt0, 32'h2);
        @(negedge clk); ex_valid = 1'b1; jump_flag = 1'b1; next_pc = 32'h200; #1;
        chk("w_b_addr", addr0, 32'h20);
        chk("w_b_flush", {31'b0, fid0}, 32'h1);
        @(negedge clk); ex_valid = 1'b0; jump_flag = 1'b0; #1;
        chk("w_c_addr", addr0, 32'h20);
        chk("w_c_req", {31'b0, req0}, 32'h1);
        chk("w_c_cnt", cnt0, 32'h3);
        @(negedge clk); #1;
        chk("w_d_addr", addr0, 32'h20);
        chk("w_d_req", {31'b0, req0}, 32'h1);
        @(negedge clk); wait_cfg = 0; #1;
        chk("w_e_addr", addr0, 32'h200);
        chk("w_e_ifv", {31'b0, ifv0}, 32'h0);

        @(negedge clk); stall = 1'b1; #1;
        chk("s_f_addr", addr0, 32'h204);
        chk("s_f_ifpc", ifpc0, 32'h200);
        chk("s_f_ifinst", ifinst0, 32'h200 ^ KEY);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("s_hold_req", {31'b0, req0}, 32'h0);
            chk("s_hold_ifpc", ifpc0, 32'h200);
            chk("s_hold_ifv", {31'b0, ifv0}, 32'h1);
        end
        @(negedge clk); stall = 1'b0; #1;
        chk("s_j_req", {31'b0, req0}, 32'h0);
        chk("s_j_ifpc", ifpc0, 32'h200);
        @(negedge clk); #1;
        chk("s_k_ifpc", ifpc0, 32'h204);
        chk("s_k_ifinst", ifinst0, 32'h204 ^ KEY);
        chk("s_k_addr", addr0, 32'h208);
        @(negedge clk); #1;
        chk("s_l_ifpc", ifpc0, 32'h208);
        chk("s_l_addr", addr0, 32'h20C);

        stall = 1'b1; ex_valid = 1'b1; jump_flag = 1'b1; next_pc = 32'h303; #1;
        chk("m_flush", {31'b0, fif0}, 32'h1);
        @(negedge clk); stall = 1'b0; ex_valid = 1'b0; jump_flag = 1'b0; #1;
        chk("m_addr", addr0, 32'h300);
        chk("m_mis", {31'b0, mis0}, 32'h1);
        chk("m_ifv", {31'b0, ifv0}, 32'h0);
        chk("m_cnt", cnt0, 32'h4);
        @(negedge clk); #1;
        chk("m_mis_end", {31'b0, mis0}, 32'h0);
        chk("m_ifpc", ifpc0, 32'h300);
        chk("m_ifv2", {31'b0, ifv0}, 32'h1);
        chk("m_addr2", addr0, 32'h304);

        wait_cfg = 3; ex_valid = 1'b1; jump_flag = 1'b1; next_pc = 32'h400;
        @(negedge clk); ex_valid = 1'b0; jump_flag = 1'b0; #1;
        chk("d_addr", addr0, 32'h304);
        chk("d_cnt", cnt0, 32'h5);
        #2 rst_n = 1'b0; #1;
        chk("ar_req", {31'b0, req0}, 32'h0);
        chk("ar_addr", addr0, 32'h0);
        chk("ar_ifv", {31'b0, ifv0}, 32'h0);
        chk("ar_ifpc", ifpc0, 32'h0);
        chk("ar_ifinst", ifinst0, NOP);
        chk("ar_cnt", cnt0, 32'h0);
        chk("ar_mis", {31'b0, mis0}, 32'h0);

        wait_cfg = 0;
        @(negedge clk); rst1_n = 1'b1; #1;
        chk("w1_req", {31'b0, req1}, 32'h0);
        chk("w1_addr", addr1, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("w2_addr", addr1, 32'hFFFF_FFF8);
        chk("w2_req", {31'b0, req1}, 32'h1);
        @(negedge clk); #1;
        chk("w3_addr", addr1, 32'hFFFF_FFFC);
        chk("w3_ifpc", ifpc1, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("w4_addr", addr1, 32'h0);
        chk("w4_ifpc", ifpc1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("w5_ifpc", ifpc1, 32'h0);
        chk("w5_ifinst", ifinst1, 32'h0 ^ KEY);
        chk("w5_ifv", {31'b0, ifv1}, 32'h1);
        chk("w5_misc", {29'b0, fif1, fid1, mis1}, 32'h0);
        chk("w5_cnt", cnt1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
